pipe_ctrl: RTL and testbench

Central pipeline stall/flush controller for the 5-stage CPU core. It collects stall requests from IF, ID, EX and MEM, tracks multi-cycle EX operations (mul/div) with an internal down-counter, and drives the 6-bit `stall` vector consumed by the PC register and every inter-stage register. Each stage register treats `stall[n]=1 && stall[n+1]=0` as "insert bubble" and `stall[n]=1 && stall[n+1]=1` as "hold". The controller also issues the exception flush and redirect PC.

---
 rtl/cpu_defs_pkg.sv | 42 ++++
 rtl/mc_counter.sv | 39 +++
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared pipeline-control encodings, FSM state type and defaults.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs_pkg;

  localparam int MC_W_DEFAULT = 6;

  // Each set bit holds that stage register; the lowest clear bit above a set
  // bit is where the bubble gets inserted.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } pc_state_e;

  function automatic logic [5:0] stall_encode(
    input logic req_mem,
    input logic req_ex,
    input logic req_id,
    input logic req_if
  );
    logic [5:0] v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_counter.sv
// ============================================================================
// Module      : mc_counter
// Description : Loadable down-counter with freeze and terminal (==1) flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_one
);

  logic [W-1:0] r_count;

  // Clear beats load beats decrement; the count never underflows past zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign is_one = (r_count == W'(1));

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : 5-stage pipeline stall/flush controller with multi-cycle EX.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int MC_W  = MC_W_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             mc_start,
  input  logic [MC_W-1:0]  mc_cycles,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cycles
);

  pc_state_e        r_state;
  pc_state_e        w_next_state;
  logic             w_cnt_clear;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_is_one;
  logic             w_in_run;
  logic             w_in_busy;
  logic             w_single;
  logic [MC_W-1:0]  w_load_val;
  logic [CNT_W-1:0] r_stall_cycles;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_in_busy  = (r_state == ST_MC_BUSY);
  // A length of 0 behaves like 1, so both finish in the start cycle.
  assign w_single   = (mc_cycles <= MC_W'(1));
  assign w_load_val = mc_cycles - MC_W'(1);

  mc_counter #(
    .W (MC_W)
  ) u_mc_counter (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (w_cnt_clear),
    .load     (w_cnt_load),
    .load_val (w_load_val),
    .dec      (w_cnt_dec),
    .is_one   (w_cnt_is_one)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!flush_req && mc_start && !w_single) begin
          w_cnt_load   = 1'b1;
          w_next_state = ST_MC_BUSY;
        end
      end
      ST_MC_BUSY: begin
        // A flush abandons the op; a MEM stall freezes it in place.
        if (flush_req) begin
          w_cnt_clear  = 1'b1;
          w_next_state = ST_RUN;
        end else if (!stallreq_mem) begin
          w_cnt_dec = 1'b1;
          if (w_cnt_is_one) begin
            w_next_state = ST_RUN;
          end
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = 32'h0;
    mc_done = 1'b0;
    if (!resetn) begin
      stall   = STALL_NONE;
    end else if (flush_req) begin
      flush   = 1'b1;
      new_pc  = flush_pc;
    end else begin
      stall   = stall_encode(stallreq_mem,
                             stallreq_ex || (w_in_run && mc_start) || w_in_busy,
                             stallreq_id,
                             stallreq_if);
      mc_done = (w_in_run && mc_start && w_single) ||
                (w_in_busy && !stallreq_mem && w_cnt_is_one);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
    end else if (stall[0]) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed plus randomized bench for pipe_ctrl with a ref model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int MC_W  = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             stallreq_if = 1'b0;
  logic             stallreq_id = 1'b0;
  logic             stallreq_ex = 1'b0;
  logic             stallreq_mem = 1'b0;
  logic             mc_start = 1'b0;
  logic [MC_W-1:0]  mc_cycles = '0;
  logic             flush_req = 1'b0;
  logic [31:0]      flush_pc = 32'h0;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             mc_done;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MC_W  (MC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .mc_start     (mc_start),
    .mc_cycles    (mc_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_done      (mc_done),
    .stall_cycles (stall_cycles)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: cycles of the op still to run after this one, and the counter.
  int m_rem = 0;
  int m_cnt = 0;

  logic [5:0]       s_stall;
  logic             s_flush;
  logic [31:0]      s_new_pc;
  logic             s_done;
  logic [CNT_W-1:0] s_sc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    mc_start     = 1'b0;
    flush_req    = 1'b0;
  endtask

  // One clock: sample and compare at negedge, advance the model at posedge.
  task automatic cycle();
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_done;
    bit          busy;
    bit          start;
    int          n;
    @(negedge clk);
    s_stall  = stall;
    s_flush  = flush;
    s_new_pc = new_pc;
    s_done   = mc_done;
    s_sc     = stall_cycles;
    busy  = (m_rem > 0);
    start = mc_start && !busy;
    n     = (mc_cycles == 0) ? 1 : int'(mc_cycles);
    e_stall = 6'b000000;
    e_flush = 1'b0;
    e_pc    = 32'h0;
    e_done  = 1'b0;
    if (!resetn) begin
      m_rem = 0;
      m_cnt = 0;
    end else if (flush_req) begin
      e_flush = 1'b1;
      e_pc    = flush_pc;
    end else begin
      if (stallreq_mem)                        e_stall = 6'b011111;
      else if (stallreq_ex || start || busy)   e_stall = 6'b001111;
      else if (stallreq_id)                    e_stall = 6'b000111;
      else if (stallreq_if)                    e_stall = 6'b000011;
      e_done = (start && n == 1) || (busy && !stallreq_mem && m_rem == 1);
    end
    chk("stall",        {26'h0, s_stall}, {26'h0, e_stall});
    chk("flush",        {31'h0, s_flush}, {31'h0, e_flush});
    chk("new_pc",       s_new_pc, e_pc);
    chk("mc_done",      {31'h0, s_done}, {31'h0, e_done});
    chk("stall_cycles", 32'(s_sc), 32'(m_cnt));
    @(posedge clk);
    if (resetn) begin
      if (flush_req)                 m_rem = 0;
      else if (busy)                 begin if (!stallreq_mem) m_rem = m_rem - 1; end
      else if (start && n > 1)       m_rem = n - 1;
      if (e_stall[0]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    cycle();
    chk("lit_rst_stall", 32'(s_stall), 32'h0);
    chk("lit_rst_flush", 32'(s_flush), 32'h0);
    chk("lit_rst_sc",    32'(s_sc),    32'h0);
    resetn = 1'b1;
    cycle();
    chk("lit_idle_stall", 32'(s_stall), 32'h0);
    stallreq_id = 1'b1;
    cycle();
    chk("lit_id_stall", 32'(s_stall), 32'b000111);
    stallreq_id = 1'b0;
    cycle();
    chk("lit_id_count", 32'(s_sc), 32'd1);
    stallreq_if  = 1'b1;
    stallreq_mem = 1'b1;
    cycle();
    chk("lit_if_mem", 32'(s_stall), 32'b011111);
    clear_inputs();

    // 5-cycle op, no MEM stall
    mc_cycles = 6'd5;
    mc_start  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      mc_start = 1'b0;
      chk("lit_mc5_stall", 32'(s_stall), (i < 5) ? 32'b001111 : 32'h0);
      chk("lit_mc5_done",  32'(s_done),  (i == 4) ? 32'd1 : 32'd0);
    end

    // 5-cycle op with a MEM stall in its third cycle
    mc_start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      stallreq_mem = (i == 2);
      cycle();
      mc_start = 1'b0;
      chk("lit_mcm_stall", 32'(s_stall),
          (i == 2) ? 32'b011111 : ((i < 6) ? 32'b001111 : 32'h0));
      chk("lit_mcm_done", 32'(s_done), (i == 5) ? 32'd1 : 32'd0);
    end
    stallreq_mem = 1'b0;

    // Flush in the third cycle of a 5-cycle op
    flush_pc = 32'hBFC00380;
    mc_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      flush_req = (i == 2);
      cycle();
      mc_start = 1'b0;
      if (i == 2) begin
        chk("lit_fl_flush",  32'(s_flush), 32'd1);
        chk("lit_fl_pc",     s_new_pc,     32'hBFC00380);
        chk("lit_fl_stall",  32'(s_stall), 32'h0);
      end else if (i > 2) begin
        chk("lit_fl_after",  32'(s_stall), 32'h0);
      end
      chk("lit_fl_done", 32'(s_done), 32'd0);
    end
    flush_req = 1'b0;

    // Zero length behaves as one cycle
    mc_cycles = 6'd0;
    mc_start  = 1'b1;
    cycle();
    chk("lit_mc0_stall", 32'(s_stall), 32'b001111);
    chk("lit_mc0_done",  32'(s_done),  32'd1);
    mc_start = 1'b0;
    cycle();
    chk("lit_mc0_rel", 32'(s_stall), 32'h0);

    // Reset in the middle of an op
    mc_cycles = 6'd5;
    mc_start  = 1'b1;
    cycle();
    mc_start = 1'b0;
    cycle();
    resetn = 1'b0;
    cycle();
    chk("lit_mrst_stall", 32'(s_stall), 32'h0);
    chk("lit_mrst_done",  32'(s_done),  32'h0);
    chk("lit_mrst_sc",    32'(s_sc),    32'h0);
    resetn = 1'b1;
    cycle();
    chk("lit_mrst_gone", 32'(s_stall), 32'h0);

    // Randomized traffic; the 8-bit counter wraps several times
    for (int i = 0; i < 3000; i++) begin
      stallreq_mem = ($urandom_range(0, 9) == 0);
      stallreq_ex  = ($urandom_range(0, 9) == 0);
      stallreq_id  = ($urandom_range(0, 9) == 0);
      stallreq_if  = ($urandom_range(0, 6) == 0);
      mc_start     = ($urandom_range(0, 9) == 0);
      mc_cycles    = ($urandom_range(0, 7) == 0) ? MC_W'($urandom_range(0, 63))
                                                 : MC_W'($urandom_range(0, 7));
      flush_req    = ($urandom_range(0, 39) == 0);
      flush_pc     = $urandom;
      resetn       = ($urandom_range(0, 199) != 0);
      cycle();
    end
    clear_inputs();
    resetn = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
